// File: rtl/combo_entry_sequencer.sv
// combo_entry_sequencer
//   Sequencing controller for the combination-lock datapath. Conditions the
//   four raw button levels into single-cycle events, steps the digit
//   selector, shifts committed digits into a 16-bit PIN register, checks the
//   PIN after the fourth digit and enforces a timed lockout after repeated
//   failures.
//
//   Optional feature: define COMBO_PIN_CHANGE_EN to allow changing the stored
//   PIN from OPEN (enter -> SET, four digits, back to OPEN). Without it the
//   stored PIN is the constant DEFAULT_PIN and SET is never reached.
//
//   All outputs come straight from flops; the `state` output exposes the FSM
//   state code for debug and checker binding.
module combo_entry_sequencer #(
  parameter int unsigned LOCKOUT_CYCLES = 100_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter logic [15:0] DEFAULT_PIN    = 16'h1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_enter,
  input  logic        btn_lock,
  output logic [3:0]  digit,
  output logic [15:0] pin_entry,
  output logic [2:0]  digit_count,
  output logic [2:0]  state,
  output logic        unlocked,
  output logic        lockout,
  output logic [1:0]  fail_count
);

  typedef enum logic [2:0] {
    stEntry   = 3'd0,
    stCheck   = 3'd1,
    stOpen    = 3'd2,
    stFail    = 3'd3,
    stLockout = 3'd4,
    stSet     = 3'd5
  } state_t;

  // The timer counts LOCKOUT_CYCLES-1 down to 0, so clog2 bits suffice.
  localparam int unsigned TIMER_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0] MAX_FAILS_2 = 2'(MAX_FAILS);

  // Button vector order: {lock, enter, down, up}
  logic [3:0] btnRaw;
  logic [3:0] btnSync1;
  logic [3:0] btnSync2;
  logic [3:0] btnPrev;
  logic [3:0] btnEvt;

  logic evtUp;
  logic evtDown;
  logic evtEnter;
  logic evtLock;

  state_t             stateQ;
  logic [TIMER_W-1:0] timerQ;
  logic [15:0]        storedPin;

  logic [3:0]  digitNext;
  logic [15:0] pinShifted;
  logic        lastDigit;
  logic [1:0]  failNext;

  assign btnRaw = {btn_lock, btn_enter, btn_down, btn_up};

  // Two-flop synchronizer followed by a registered rising-edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btnSync1 <= '0;
      btnSync2 <= '0;
      btnPrev  <= '0;
      btnEvt   <= '0;
    end else begin
      btnSync1 <= btnRaw;
      btnSync2 <= btnSync1;
      btnPrev  <= btnSync2;
      btnEvt   <= btnSync2 & ~btnPrev;
    end
  end

  assign evtUp    = btnEvt[0];
  assign evtDown  = btnEvt[1];
  assign evtEnter = btnEvt[2];
  assign evtLock  = btnEvt[3];

  // Digit selector step; up and down in the same cycle cancel out.
  always_comb begin
    digitNext = digit;
    if (evtUp && !evtDown) begin
      digitNext = digit + 4'd1;
    end else if (evtDown && !evtUp) begin
      digitNext = digit - 4'd1;
    end
  end

  assign pinShifted = {pin_entry[11:0], digit};
  assign lastDigit  = (digit_count == 3'd3);
  assign failNext   = (fail_count >= MAX_FAILS_2) ? MAX_FAILS_2 : fail_count + 2'd1;

`ifndef COMBO_PIN_CHANGE_EN
  assign storedPin = DEFAULT_PIN;
`endif

  // Main sequencer FSM; every output is registered here alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ      <= stEntry;
      digit       <= 4'd0;
      pin_entry   <= 16'd0;
      digit_count <= 3'd0;
      fail_count  <= 2'd0;
      unlocked    <= 1'b0;
      lockout     <= 1'b0;
      timerQ      <= '0;
`ifdef COMBO_PIN_CHANGE_EN
      storedPin   <= DEFAULT_PIN;
`endif
    end else begin
      case (stateQ)
        stEntry: begin
          if (evtLock) begin
            digit       <= 4'd0;
            pin_entry   <= 16'd0;
            digit_count <= 3'd0;
          end else if (evtEnter) begin
            pin_entry   <= pinShifted;
            digit_count <= digit_count + 3'd1;
            digit       <= 4'd0;
            if (lastDigit) begin
              stateQ <= stCheck;
            end
          end else begin
            digit <= digitNext;
          end
        end

        stCheck: begin
          if (pin_entry == storedPin) begin
            stateQ     <= stOpen;
            unlocked   <= 1'b1;
            fail_count <= 2'd0;
          end else begin
            fail_count <= failNext;
            if (failNext == MAX_FAILS_2) begin
              stateQ  <= stLockout;
              lockout <= 1'b1;
              timerQ  <= TIMER_LOAD;
            end else begin
              stateQ <= stFail;
            end
          end
        end

        stOpen: begin
          if (evtLock) begin
            stateQ      <= stEntry;
            unlocked    <= 1'b0;
            digit       <= 4'd0;
            pin_entry   <= 16'd0;
            digit_count <= 3'd0;
`ifdef COMBO_PIN_CHANGE_EN
          end else if (evtEnter) begin
            stateQ      <= stSet;
            digit       <= 4'd0;
            pin_entry   <= 16'd0;
            digit_count <= 3'd0;
`endif
          end
        end

        stFail: begin
          if (evtLock || evtEnter) begin
            stateQ      <= stEntry;
            digit       <= 4'd0;
            pin_entry   <= 16'd0;
            digit_count <= 3'd0;
          end
        end

        stLockout: begin
          // Events are deliberately ignored until the timer expires.
          if (timerQ == '0) begin
            stateQ      <= stEntry;
            lockout     <= 1'b0;
            fail_count  <= 2'd0;
            digit       <= 4'd0;
            pin_entry   <= 16'd0;
            digit_count <= 3'd0;
          end else begin
            timerQ <= timerQ - 1'b1;
          end
        end

`ifdef COMBO_PIN_CHANGE_EN
        stSet: begin
          if (evtLock) begin
            // Abort leaves the stored PIN untouched.
            stateQ      <= stOpen;
            digit       <= 4'd0;
            pin_entry   <= 16'd0;
            digit_count <= 3'd0;
          end else if (evtEnter) begin
            if (lastDigit) begin
              storedPin   <= pinShifted;
              stateQ      <= stOpen;
              digit       <= 4'd0;
              pin_entry   <= 16'd0;
              digit_count <= 3'd0;
            end else begin
              pin_entry   <= pinShifted;
              digit_count <= digit_count + 3'd1;
              digit       <= 4'd0;
            end
          end else begin
            digit <= digitNext;
          end
        end
`endif

        default: begin
          stateQ      <= stEntry;
          unlocked    <= 1'b0;
          lockout     <= 1'b0;
          digit       <= 4'd0;
          pin_entry   <= 16'd0;
          digit_count <= 3'd0;
        end
      endcase
    end
  end

  assign state = stateQ;

endmodule

// File: tb/tb_combo_entry_sequencer.sv
// Directed bench for combo_entry_sequencer, built with a 16-cycle lockout.
// Covers both builds; the PIN-change section follows COMBO_PIN_CHANGE_EN.
module tb_combo_entry_sequencer;

  localparam logic [3:0] B_UP    = 4'b0001;
  localparam logic [3:0] B_DOWN  = 4'b0010;
  localparam logic [3:0] B_ENTER = 4'b0100;
  localparam logic [3:0] B_LOCK  = 4'b1000;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        btnUp = 1'b0;
  logic        btnDown = 1'b0;
  logic        btnEnter = 1'b0;
  logic        btnLock = 1'b0;
  logic [3:0]  digit;
  logic [15:0] pinEntry;
  logic [2:0]  digitCount;
  logic [2:0]  state;
  logic        unlocked;
  logic        lockout;
  logic [1:0]  failCount;

  int errors = 0;
  int checks = 0;
  int cnt;

  combo_entry_sequencer #(
    .LOCKOUT_CYCLES(16),
    .MAX_FAILS(3),
    .DEFAULT_PIN(16'h1234)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btnUp),
    .btn_down(btnDown),
    .btn_enter(btnEnter),
    .btn_lock(btnLock),
    .digit(digit),
    .pin_entry(pinEntry),
    .digit_count(digitCount),
    .state(state),
    .unlocked(unlocked),
    .lockout(lockout),
    .fail_count(failCount)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: raise the masked buttons, hold until the resulting update edge
  // has passed (event after edge N+2, update at N+3), then release
  task automatic pulse(input logic [3:0] m);
    repeat (3) @(negedge clk);
    {btnLock, btnEnter, btnDown, btnUp} = m;
    repeat (4) @(negedge clk);
    {btnLock, btnEnter, btnDown, btnUp} = 4'b0000;
  endtask

  task automatic enterDigit(input int d);
    for (int i = 0; i < d; i++) pulse(B_UP);
    pulse(B_ENTER);
  endtask

  task automatic enterPin(input logic [15:0] p);
    logic [15:0] v;
    v = p;
    enterDigit(int'(v[15:12]));
    enterDigit(int'(v[11:8]));
    enterDigit(int'(v[7:4]));
    enterDigit(int'(v[3:0]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_state", 16'(state), 16'd0);
    check("rst_digit", 16'(digit), 16'd0);
    check("rst_pin", pinEntry, 16'h0000);
    check("rst_count", 16'(digitCount), 16'd0);
    check("rst_unlocked", 16'(unlocked), 16'd0);
    check("rst_lockout", 16'(lockout), 16'd0);
    check("rst_fails", 16'(failCount), 16'd0);

    // correct PIN 1,2,3,4
    enterDigit(1);
    enterDigit(2);
    enterDigit(3);
    check("pin_three", pinEntry, 16'h0123);
    check("count_three", 16'(digitCount), 16'd3);
    enterDigit(4);
    check("pin_full", pinEntry, 16'h1234);
    check("count_full", 16'(digitCount), 16'd4);
    check("check_state", 16'(state), 16'd1);
    @(negedge clk);
    check("open_state", 16'(state), 16'd2);
    check("open_unlocked", 16'(unlocked), 16'd1);
    check("open_fails", 16'(failCount), 16'd0);

    // up in OPEN must not touch the digit
    pulse(B_UP);
    check("open_up_digit", 16'(digit), 16'd0);

`ifdef COMBO_PIN_CHANGE_EN
    pulse(B_ENTER);
    check("set_state", 16'(state), 16'd5);
    check("set_unlocked", 16'(unlocked), 16'd1);
    enterPin(16'h9876);
    check("set_done_state", 16'(state), 16'd2);
    check("set_done_pin", pinEntry, 16'h0000);
    pulse(B_LOCK);
    check("relock_state", 16'(state), 16'd0);
    enterPin(16'h9876);
    @(negedge clk);
    check("newpin_state", 16'(state), 16'd2);
    check("newpin_unlocked", 16'(unlocked), 16'd1);
    pulse(B_LOCK);
    enterPin(16'h1234);
    @(negedge clk);
    check("oldpin_state", 16'(state), 16'd3);
    check("oldpin_fails", 16'(failCount), 16'd1);
    pulse(B_ENTER);
    enterPin(16'h9876);
    @(negedge clk);
    check("newpin2_state", 16'(state), 16'd2);
    check("newpin2_fails", 16'(failCount), 16'd0);
`else
    pulse(B_ENTER);
    check("open_enter_state", 16'(state), 16'd2);
    check("open_enter_unlocked", 16'(unlocked), 16'd1);
    pulse(B_LOCK);
    enterPin(16'h1234);
    @(negedge clk);
    check("reopen_state", 16'(state), 16'd2);
`endif

    // lock in OPEN
    pulse(B_LOCK);
    check("lock_open_state", 16'(state), 16'd0);
    check("lock_open_unlocked", 16'(unlocked), 16'd0);
    check("lock_open_pin", pinEntry, 16'h0000);

    // digit wrap and simultaneous presses
    pulse(B_DOWN);
    check("wrap_down", 16'(digit), 16'h000f);
    pulse(B_UP);
    check("wrap_up", 16'(digit), 16'd0);
    for (int i = 0; i < 5; i++) pulse(B_UP);
    check("digit_five", 16'(digit), 16'd5);
    pulse(B_UP | B_DOWN);
    check("updown_same", 16'(digit), 16'd5);
    pulse(B_ENTER | B_UP);
    check("enter_up_pin", pinEntry, 16'h0005);
    check("enter_up_digit", 16'(digit), 16'd0);
    check("enter_up_count", 16'(digitCount), 16'd1);

    // abort after two digits
    enterDigit(2);
    check("two_pin", pinEntry, 16'h0052);
    pulse(B_LOCK);
    check("abort_pin", pinEntry, 16'h0000);
    check("abort_count", 16'(digitCount), 16'd0);
    check("abort_state", 16'(state), 16'd0);

    // lockout: three wrong attempts of 0000
    enterPin(16'h0000);
    @(negedge clk);
    check("fail1_state", 16'(state), 16'd3);
    check("fail1_count", 16'(failCount), 16'd1);
    pulse(B_ENTER);
    check("fail1_exit", 16'(state), 16'd0);
    enterPin(16'h0000);
    @(negedge clk);
    check("fail2_state", 16'(state), 16'd3);
    check("fail2_count", 16'(failCount), 16'd2);
    pulse(B_ENTER);
    enterPin(16'h0000);
    check("fail3_check", 16'(state), 16'd1);
    @(negedge clk);
    check("lock_state", 16'(state), 16'd4);
    check("lock_fails", 16'(failCount), 16'd3);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (!lockout) break;
      cnt++;
      if (i == 1) {btnLock, btnEnter, btnDown, btnUp} = 4'b1101;
      if (i == 8) {btnLock, btnEnter, btnDown, btnUp} = 4'b0000;
      @(negedge clk);
    end
    check("lockout_cycles", 16'(cnt), 16'd16);
    check("post_lock_state", 16'(state), 16'd0);
    check("post_lock_fails", 16'(failCount), 16'd0);
    check("post_lock_digit", 16'(digit), 16'd0);
    check("post_lock_pin", pinEntry, 16'h0000);

    // async reset in the middle of a lockout
    for (int a = 0; a < 3; a++) begin
      enterPin(16'h0000);
      @(negedge clk);
      if (a < 2) pulse(B_ENTER);
    end
    check("relock_lockout", 16'(lockout), 16'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_state", 16'(state), 16'd0);
    check("arst_lockout", 16'(lockout), 16'd0);
    check("arst_fails", 16'(failCount), 16'd0);
    check("arst_count", 16'(digitCount), 16'd0);
    check("arst_unlocked", 16'(unlocked), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // default PIN is live again after reset
    enterPin(16'h1234);
    @(negedge clk);
    check("after_rst_open", 16'(state), 16'd2);
    check("after_rst_unlocked", 16'(unlocked), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
